// File: rtl/apb4_pkg.sv
// Shared APB4 initiator types: FSM states, PPROT bit positions,
// and a default-width request bundle for integrators.
package apb4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int PPROT_PRIVILEGED  = 0;
   localparam int PPROT_NONSECURE   = 1;
   localparam int PPROT_INSTRUCTION = 2;

   localparam int REQ_ADDR_W = 8;
   localparam int REQ_DATA_W = 8;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0]   addr;
      logic                    write;
      logic [REQ_DATA_W-1:0]   wdata;
      logic [REQ_DATA_W/8-1:0] strb;
      logic [2:0]              prot;
   } apb_req_t;

endpackage

// File: rtl/apb4_watchdog.sv
// Stall watchdog: counts stalled ACCESS cycles, saturates at TIMEOUT,
// raises a sticky flag. Ports: clk_i, rst_ni, restart_i, stall_i, clr_i, timeout_o.
module apb4_watchdog
   import apb4_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   input  logic stall_i,
   input  logic clr_i,
   output logic timeout_o
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          hit;

   always_comb begin
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (restart_i) begin
         cnt_d = '0;
      end else if (stall_i && (TIMEOUT != 0)) begin
         if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
         // Saturated counter keeps re-asserting the set so it beats a clear
         hit = (cnt_d == LIMIT);
      end
      flag_d = hit ? 1'b1 : (clr_i ? 1'b0 : flag_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign timeout_o = flag_q;

endmodule

// File: rtl/apb4_master.sv
// APB4 initiator: valid/ready request -> SETUP/ACCESS transfer -> 1-cycle response.
// Ports: req_* in, rsp_* out, timeout/timeout_clr, APB4 P* bus signals.
module apb4_master
   import apb4_pkg::*;
#(
   parameter int PADDR_SIZE = 8,
   parameter int PDATA_SIZE = 8,
   parameter int TIMEOUT    = 256
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [PADDR_SIZE-1:0]   req_addr,
   input  logic                    req_write,
   input  logic [PDATA_SIZE-1:0]   req_wdata,
   input  logic [PDATA_SIZE/8-1:0] req_strb,
   input  logic [2:0]              req_prot,
   output logic                    rsp_valid,
   output logic [PDATA_SIZE-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    timeout,
   input  logic                    timeout_clr,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [PADDR_SIZE-1:0]   PADDR,
   output logic [PDATA_SIZE-1:0]   PWDATA,
   output logic [PDATA_SIZE/8-1:0] PSTRB,
   output logic [2:0]              PPROT,
   input  logic [PDATA_SIZE-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   apb_state_e state_q, state_d;

   logic                    accept, done;
   logic                    psel_d, penable_d;
   logic [PADDR_SIZE-1:0]   paddr_q;
   logic                    pwrite_q;
   logic [PDATA_SIZE-1:0]   pwdata_q;
   logic [PDATA_SIZE/8-1:0] pstrb_q;
   logic [2:0]              pprot_q;
   logic                    rsp_valid_q, rsp_err_q;
   logic [PDATA_SIZE-1:0]   rsp_rdata_q;

   // Ready is combinational from PREADY so a new request can ride the
   // completion edge and go straight back to SETUP.
   assign req_ready = PRESETn &
                      ((state_q == ST_IDLE) |
                       ((state_q == ST_ACCESS) & PREADY));
   assign accept = req_valid & req_ready;
   assign done   = (state_q == ST_ACCESS) & PREADY;

   always_comb begin
      state_d   = state_q;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            psel_d  = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            if (PREADY) state_d = accept ? ST_SETUP : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         pprot_q  <= '0;
      end else if (accept) begin
         paddr_q  <= req_addr;
         pwrite_q <= req_write;
         pwdata_q <= req_write ? req_wdata : '0;
         pstrb_q  <= req_write ? req_strb : '0;
         pprot_q  <= req_prot;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= done;
         if (done) begin
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_err_q   <= PSLVERR;
         end
      end
   end

   apb4_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i     (PCLK),
      .rst_ni    (PRESETn),
      .restart_i (accept),
      .stall_i   ((state_q == ST_ACCESS) & ~PREADY),
      .clr_i     (timeout_clr),
      .timeout_o (timeout)
   );

   assign PSEL      = psel_d;
   assign PENABLE   = penable_d;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PSTRB     = pstrb_q;
   assign PPROT     = pprot_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master with a wait-state/error APB slave
// model and a memory-level reference model of expected responses.
module tb_apb4_master;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_addr = '0;
   logic       req_write = 1'b0;
   logic [7:0] req_wdata = '0;
   logic [0:0] req_strb = '0;
   logic [2:0] req_prot = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       timeout;
   logic       timeout_clr = 1'b0;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA;
   logic [0:0] PSTRB;
   logic [2:0] PPROT;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   apb4_master #(
      .PADDR_SIZE (8),
      .PDATA_SIZE (8),
      .TIMEOUT    (4)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .req_strb    (req_strb),
      .req_prot    (req_prot),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .timeout     (timeout),
      .timeout_clr (timeout_clr),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PSTRB       (PSTRB),
      .PPROT       (PPROT),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int pass_cnt = 0;
   int total_cnt = 0;

   // transaction table shared by the requester side and the slave model
   logic [7:0] tx_addr [128];
   logic [7:0] tx_wd   [128];
   logic [2:0] tx_prot [128];
   logic       tx_wr   [128];
   logic       tx_strb [128];
   logic       tx_err  [128];
   int         tx_wait [128];
   int         tix = 0;

   // slave model: memory, wait states and error taken from the table
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int         slv_idx = 0;
   int         wait_left = 0;
   logic       cur_err = 1'b0;

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'h96;
      mem[8'h3C] = 8'hA5;
   end

   assign PREADY  = (wait_left == 0);
   assign PRDATA  = mem[PADDR];
   assign PSLVERR = PSEL & PENABLE & (wait_left == 0) & cur_err;

   always @(posedge PCLK) begin
      if (PSEL && !PENABLE) begin
         wait_left <= tx_wait[slv_idx];
         cur_err   <= tx_err[slv_idx];
         slv_idx   <= slv_idx + 1;
      end else if (PSEL && PENABLE) begin
         if (wait_left != 0) wait_left <= wait_left - 1;
         else if (PWRITE && PSTRB[0] && !cur_err) mem[PADDR] <= PWDATA;
      end
   end

   // per-run observation record (cycle-indexed)
   logic       psel_h [512];
   logic       pen_h  [512];
   logic       to_h   [512];
   logic       pstrb_h[512];
   logic [7:0] paddr_h[512];
   logic [7:0] pwd_h  [512];
   logic [2:0] pprot_h[512];
   int         acc_c  [128];
   int         rsp_c  [128];
   logic [7:0] rsp_d  [128];
   logic       rsp_e  [128];
   int         got;

   task automatic add_tx(input logic [7:0] a, input logic wr,
                         input logic [7:0] wd, input logic st,
                         input int w, input logic er);
      tx_addr[tix] = a;
      tx_wr[tix]   = wr;
      tx_wd[tix]   = wd;
      tx_strb[tix] = st;
      tx_wait[tix] = w;
      tx_err[tix]  = er;
      tx_prot[tix] = 3'($urandom_range(0, 7));
      tix++;
   endtask

   // expected response from the memory-level model; applies writes in order
   task automatic model(input int i, output logic [7:0] rd, output logic er);
      er = tx_err[i];
      if (tx_wr[i]) begin
         rd = 8'h00;
         if (tx_strb[i] && !tx_err[i]) ref_mem[tx_addr[i]] = tx_wd[i];
      end else begin
         rd = ref_mem[tx_addr[i]];
      end
   endtask

   // issue table entries first..first+n-1 with req_valid held, record bus
   task automatic run(input int first, input int n, input int max_cyc,
                      input int clr_off);
      int  nxt;
      int  cyc;
      bit  acc;
      nxt = first;
      cyc = 0;
      got = 0;
      while ((nxt < first + n || got < n) && cyc < max_cyc) begin
         if (nxt < first + n) begin
            req_valid = 1'b1;
            req_addr  = tx_addr[nxt];
            req_write = tx_wr[nxt];
            req_wdata = tx_wd[nxt];
            req_strb  = tx_strb[nxt];
            req_prot  = tx_prot[nxt];
         end else begin
            req_valid = 1'b0;
         end
         timeout_clr = (clr_off >= 0) && (nxt > first) &&
                       (cyc == acc_c[0] + clr_off);
         acc = req_valid && req_ready;
         @(posedge PCLK);
         #1;
         cyc++;
         if (acc) begin
            acc_c[nxt - first] = cyc;
            nxt++;
         end
         psel_h[cyc]  = PSEL;
         pen_h[cyc]   = PENABLE;
         to_h[cyc]    = timeout;
         pstrb_h[cyc] = PSTRB[0];
         paddr_h[cyc] = PADDR;
         pwd_h[cyc]   = PWDATA;
         pprot_h[cyc] = PPROT;
         if (rsp_valid) begin
            if (got < n) begin
               rsp_c[got] = cyc;
               rsp_d[got] = rsp_rdata;
               rsp_e[got] = rsp_err;
            end
            got++;
         end
      end
      req_valid   = 1'b0;
      timeout_clr = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn   = 1'b0;
      req_valid = 1'b1;
      req_addr  = 8'h77;
      req_write = 1'b1;
      req_wdata = 8'hEE;
      req_strb  = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      total_cnt++;
      if (req_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", req_ready);
      else pass_cnt++;
      total_cnt++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, timeout} !== 6'b0)
         $display("FAIL reset_ctrl got %b exp 000000",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, timeout});
      else pass_cnt++;
      total_cnt++;
      if ({PADDR, PWDATA, PSTRB, PPROT, rsp_rdata} !== 28'h0)
         $display("FAIL reset_data got %h exp 0",
                  {PADDR, PWDATA, PSTRB, PPROT, rsp_rdata});
      else pass_cnt++;
      req_valid = 1'b0;
      PRESETn   = 1'b1;
      @(posedge PCLK);
      #1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", req_ready);
      else pass_cnt++;
   endtask

   task automatic test_single_read();
      int         i0, a;
      logic [7:0] ed;
      logic       ee;
      i0 = tix;
      add_tx(8'h3C, 1'b0, 8'hC3, 1'b1, 0, 1'b0);
      run(i0, 1, 20, -1);
      model(i0, ed, ee);
      a = acc_c[0];
      total_cnt++;
      if (got !== 1) $display("FAIL rd_count got %0d exp 1", got);
      else pass_cnt++;
      total_cnt++;
      if ({psel_h[a], pen_h[a], psel_h[a+1], pen_h[a+1]} !== 4'b1011)
         $display("FAIL rd_phases got %b exp 1011",
                  {psel_h[a], pen_h[a], psel_h[a+1], pen_h[a+1]});
      else pass_cnt++;
      total_cnt++;
      if (rsp_c[0] - a !== 2) $display("FAIL rd_latency got %0d exp 2", rsp_c[0] - a);
      else pass_cnt++;
      total_cnt++;
      if (rsp_d[0] !== 8'hA5 || ed !== 8'hA5 || rsp_e[0] !== 1'b0)
         $display("FAIL rd_data got %h/%b exp a5/0", rsp_d[0], rsp_e[0]);
      else pass_cnt++;
      total_cnt++;
      if ({pstrb_h[a], pstrb_h[a+1], pwd_h[a], pwd_h[a+1]} !== 18'h0)
         $display("FAIL rd_strb_wdata got %b%b %h %h exp 0",
                  pstrb_h[a], pstrb_h[a+1], pwd_h[a], pwd_h[a+1]);
      else pass_cnt++;
      total_cnt++;
      if (pprot_h[a] !== tx_prot[i0] || paddr_h[a] !== 8'h3C)
         $display("FAIL rd_addr_prot got %h/%h exp 3c/%h",
                  paddr_h[a], pprot_h[a], tx_prot[i0]);
      else pass_cnt++;
      total_cnt++;
      if (psel_h[a+2] !== 1'b0) $display("FAIL rd_idle_psel got %b exp 0", psel_h[a+2]);
      else pass_cnt++;
   endtask

   task automatic test_wait_write();
      int         i0, a, nsel, bad;
      logic [7:0] ed;
      logic       ee;
      i0 = tix;
      add_tx(8'h10, 1'b1, 8'h5A, 1'b1, 3, 1'b0);
      run(i0, 1, 30, -1);
      model(i0, ed, ee);
      a = acc_c[0];
      nsel = 0;
      bad = 0;
      for (int c = a; c < rsp_c[0]; c++) begin
         if (psel_h[c]) nsel++;
         if (paddr_h[c] !== 8'h10 || pwd_h[c] !== 8'h5A || pstrb_h[c] !== 1'b1) bad++;
      end
      total_cnt++;
      if (got !== 1 || nsel !== 5) $display("FAIL wr_psel_cycles got %0d/%0d exp 1/5", got, nsel);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL wr_stable got %0d unstable cycles exp 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (rsp_d[0] !== ed || rsp_e[0] !== ee)
         $display("FAIL wr_rsp got %h/%b exp %h/%b", rsp_d[0], rsp_e[0], ed, ee);
      else pass_cnt++;
      i0 = tix;
      add_tx(8'h10, 1'b0, 8'h00, 1'b0, 1, 1'b0);
      run(i0, 1, 30, -1);
      model(i0, ed, ee);
      total_cnt++;
      if (got !== 1 || rsp_d[0] !== ed || ed !== 8'h5A)
         $display("FAIL wr_readback got %h exp %h", rsp_d[0], ed);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int         i0, a, bad;
      logic [7:0] ed;
      logic       ee;
      i0 = tix;
      for (int k = 0; k < 4; k++)
         add_tx(8'($urandom_range(32, 47)), 1'b1, 8'($urandom), 1'b1, 0, 1'b0);
      for (int k = 0; k < 4; k++)
         add_tx(tx_addr[i0 + k], 1'b0, 8'h00, 1'b0, 0, 1'b0);
      run(i0, 8, 60, -1);
      a = acc_c[0];
      bad = 0;
      for (int j = 0; j < 8; j++)
         if (psel_h[a+j] !== 1'b1 || pen_h[a+j] !== j[0]) bad++;
      total_cnt++;
      if (bad !== 0) $display("FAIL b2b_psel_pen got %0d bad cycles exp 0", bad);
      else pass_cnt++;
      bad = 0;
      for (int k = 0; k < 7; k++) begin
         if (acc_c[k+1] - acc_c[k] !== 2) bad++;
         if (rsp_c[k+1] - rsp_c[k] !== 2) bad++;
      end
      total_cnt++;
      if (got !== 8 || bad !== 0) $display("FAIL b2b_spacing got %0d rsp %0d bad exp 8/0", got, bad);
      else pass_cnt++;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         model(i0 + k, ed, ee);
         if (rsp_d[k] !== ed || rsp_e[k] !== ee) bad++;
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL b2b_data got %0d wrong responses exp 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_error();
      int         i0;
      logic [7:0] ed0, ed1;
      logic       ee0, ee1;
      i0 = tix;
      add_tx(8'h05, 1'b0, 8'h00, 1'b0, 1, 1'b1);
      add_tx(8'h06, 1'b0, 8'h00, 1'b0, 0, 1'b0);
      run(i0, 2, 30, -1);
      model(i0, ed0, ee0);
      model(i0 + 1, ed1, ee1);
      total_cnt++;
      if (got !== 2 || rsp_e[0] !== 1'b1 || rsp_e[1] !== 1'b0)
         $display("FAIL err_flag got %0d %b%b exp 2 10", got, rsp_e[0], rsp_e[1]);
      else pass_cnt++;
      total_cnt++;
      if (rsp_d[0] !== ed0 || rsp_d[1] !== ed1)
         $display("FAIL err_data got %h %h exp %h %h", rsp_d[0], rsp_d[1], ed0, ed1);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int         i0, bad, tbad;
      logic [7:0] ed;
      logic       ee;
      i0 = tix;
      for (int k = 0; k < 24; k++)
         add_tx(8'($urandom_range(0, 15)), 1'($urandom), 8'($urandom),
                1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      run(i0, 24, 300, -1);
      total_cnt++;
      if (got !== 24) $display("FAIL rand_count got %0d exp 24", got);
      else pass_cnt++;
      for (int k = 0; k < 24; k++) begin
         model(i0 + k, ed, ee);
         total_cnt++;
         if (rsp_d[k] !== ed || rsp_e[k] !== ee)
            $display("FAIL rand_rsp[%0d] got %h/%b exp %h/%b", k, rsp_d[k], rsp_e[k], ed, ee);
         else pass_cnt++;
      end
      bad = 0;
      tbad = 0;
      for (int k = 0; k < 24; k++)
         if (rsp_c[k] - acc_c[k] !== 2 + tx_wait[i0 + k]) bad++;
      for (int c = 1; c <= rsp_c[23]; c++)
         if (to_h[c] !== 1'b0) tbad++;
      total_cnt++;
      if (bad !== 0 || tbad !== 0)
         $display("FAIL rand_timing got %0d latency / %0d timeout errors exp 0/0", bad, tbad);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int         i0, a;
      logic [7:0] ed;
      logic       ee;
      i0 = tix;
      add_tx(8'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b0, 6, 1'b0);
      run(i0, 1, 40, -1);
      model(i0, ed, ee);
      a = acc_c[0];
      total_cnt++;
      if ({to_h[a+4], to_h[a+5]} !== 2'b01)
         $display("FAIL to_set got %b%b exp 01", to_h[a+4], to_h[a+5]);
      else pass_cnt++;
      total_cnt++;
      if (got !== 1 || rsp_d[0] !== ed || rsp_c[0] - a !== 8)
         $display("FAIL to_complete got %0d %h lat %0d exp 1 %h 8", got, rsp_d[0], rsp_c[0] - a, ed);
      else pass_cnt++;
      timeout_clr = 1'b1;
      @(posedge PCLK);
      #1;
      timeout_clr = 1'b0;
      total_cnt++;
      if (timeout !== 1'b0) $display("FAIL to_clear got %b exp 0", timeout);
      else pass_cnt++;
      i0 = tix;
      add_tx(8'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b0, 4, 1'b0);
      run(i0, 1, 40, 4);
      model(i0, ed, ee);
      a = acc_c[0];
      total_cnt++;
      if ({to_h[a+4], to_h[a+5]} !== 2'b01)
         $display("FAIL to_set_wins got %b%b exp 01", to_h[a+4], to_h[a+5]);
      else pass_cnt++;
      total_cnt++;
      if (got !== 1 || rsp_d[0] !== ed) $display("FAIL to_rsp2 got %h exp %h", rsp_d[0], ed);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int         i0, nrsp;
      bit         acc, accepted;
      logic [7:0] ed;
      logic       ee;
      i0 = tix;
      add_tx(8'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b0, 5, 1'b0);
      req_valid = 1'b1;
      req_addr  = tx_addr[i0];
      req_write = 1'b0;
      req_prot  = tx_prot[i0];
      accepted  = 1'b0;
      for (int c = 0; c < 10 && !accepted; c++) begin
         acc = req_valid && req_ready;
         @(posedge PCLK);
         #1;
         if (acc) accepted = 1'b1;
      end
      req_valid = 1'b0;
      @(posedge PCLK);
      #1;
      total_cnt++;
      if (!accepted || {PSEL, PENABLE} !== 2'b11)
         $display("FAIL mid_access got acc=%b %b%b exp 1 11", accepted, PSEL, PENABLE);
      else pass_cnt++;
      PRESETn = 1'b0;
      @(posedge PCLK);
      #1;
      total_cnt++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b000)
         $display("FAIL mid_reset got %b%b%b exp 000", PSEL, PENABLE, rsp_valid);
      else pass_cnt++;
      PRESETn = 1'b1;
      nrsp = 0;
      repeat (8) begin
         @(posedge PCLK);
         #1;
         if (rsp_valid || PSEL) nrsp++;
      end
      total_cnt++;
      if (nrsp !== 0) $display("FAIL mid_no_rsp got %0d activity cycles exp 0", nrsp);
      else pass_cnt++;
      i0 = tix;
      add_tx(8'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b0, 1, 1'b0);
      run(i0, 1, 20, -1);
      model(i0, ed, ee);
      total_cnt++;
      if (got !== 1 || rsp_d[0] !== ed || rsp_e[0] !== ee)
         $display("FAIL mid_after got %0d %h/%b exp 1 %h/%b", got, rsp_d[0], rsp_e[0], ed, ee);
      else pass_cnt++;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k) ^ 8'h96;
      ref_mem[8'h3C] = 8'hA5;
      test_reset();
      test_single_read();
      test_wait_write();
      test_back_to_back();
      test_error();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got expired exp done");
      $fatal(1);
   end

endmodule
